stream_product_collector: RTL and testbench

- Receive end of the bit-serial product stream produced by the streaming multiplier.
- Collects 2*WIDTH serial product bits per frame, LSB- or MSB-first, into a parallel word.
- Presents the word on a valid/ready handshake for the readout logic.
- Double-buffered: the next frame can be collected while the previous word waits to be read.

---
 rtl/stream_product_collector.sv | 126 ++++++++++++
 tb/tb_stream_product_collector.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_product_collector.sv
// Deserialises a 2*WIDTH-bit serial product frame into a parallel word and
// presents it on a valid/ready interface. The next frame can be collected while the previous word is still unread.
module stream_product_collector #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          bit_in,
  input  logic                          bit_valid,
  input  logic                          start,
  output logic [2*WIDTH-1:0]            word_out,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic                          busy,
  output logic [$clog2(2*WIDTH):0]      bit_count,
  output logic                          overrun,
  output logic                          frame_err,
  input  logic                          clear_err
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(PW) + 1;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   shift_reg, shift_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [PW-1:0]   word_reg, word_next;
  logic            valid_reg, valid_next;
  logic            overrun_reg, overrun_next;
  logic            frame_err_reg, frame_err_next;

  logic [PW-1:0]   shift_base;
  logic [PW-1:0]   frame_word;
  logic [CW-1:0]   count_inc;
  logic            accept;
  logic            complete;
  logic            overrun_set;
  logic            frame_err_set;

  // A start bit always begins from an empty register, so a restart discards the partial frame.
  assign shift_base = start ? '0 : shift_reg;

  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign frame_word = {bit_in, shift_base[PW-1:1]};
    end else begin : g_msb_first
      assign frame_word = {shift_base[PW-2:0], bit_in};
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    count_next     = count_reg;
    word_next      = word_reg;
    valid_next     = valid_reg;
    overrun_next   = overrun_reg;
    frame_err_next = frame_err_reg;
    overrun_set    = 1'b0;

    accept        = ena & bit_valid & (start | (state_reg == COLLECT));
    count_inc     = start ? CW'(1) : count_reg + CW'(1);
    complete      = accept & (count_inc == CW'(PW));
    frame_err_set = accept & start & (state_reg == COLLECT);

    if (accept) begin
      if (complete) begin
        state_next = IDLE;
        shift_next = '0;
        count_next = '0;
      end else begin
        state_next = COLLECT;
        shift_next = frame_word;
        count_next = count_inc;
      end
    end

    // A completed frame may replace the held word only if that word is leaving this cycle.
    if (ena) begin
      if (complete) begin
        if (!valid_reg || word_ready) begin
          word_next  = frame_word;
          valid_next = 1'b1;
        end else begin
          overrun_set = 1'b1;
        end
      end else if (valid_reg && word_ready) begin
        valid_next = 1'b0;
      end
      overrun_next   = (overrun_reg & ~clear_err) | overrun_set;
      frame_err_next = (frame_err_reg & ~clear_err) | frame_err_set;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      count_reg     <= '0;
      word_reg      <= '0;
      valid_reg     <= 1'b0;
      overrun_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      count_reg     <= count_next;
      word_reg      <= word_next;
      valid_reg     <= valid_next;
      overrun_reg   <= overrun_next;
      frame_err_reg <= frame_err_next;
    end
  end

  assign word_out   = word_reg;
  assign word_valid = valid_reg;
  assign busy       = (state_reg == COLLECT);
  assign bit_count  = count_reg;
  assign overrun    = overrun_reg;
  assign frame_err  = frame_err_reg;

endmodule

// File: tb/tb_stream_product_collector.sv
// Directed bench for stream_product_collector: an LSB-first instance for most
// scenarios plus an MSB-first instance for the gapped-stream case.
module tb_stream_product_collector;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        bit_in;
  logic        bit_valid;
  logic        start;
  logic [15:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic        busy;
  logic [4:0]  bit_count;
  logic        overrun;
  logic        frame_err;
  logic        clear_err;

  logic        m_ena;
  logic        m_bit_in;
  logic        m_bit_valid;
  logic        m_start;
  logic [15:0] m_word_out;
  logic        m_word_valid;
  logic        m_word_ready;
  logic        m_busy;
  logic [4:0]  m_bit_count;
  logic        m_overrun;
  logic        m_frame_err;
  logic        m_clear_err;

  int n_checks = 0;
  int n_fail   = 0;

  stream_product_collector #(.WIDTH(8), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bit_in(bit_in), .bit_valid(bit_valid),
    .start(start), .word_out(word_out), .word_valid(word_valid),
    .word_ready(word_ready), .busy(busy), .bit_count(bit_count),
    .overrun(overrun), .frame_err(frame_err), .clear_err(clear_err)
  );

  stream_product_collector #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .ena(m_ena), .bit_in(m_bit_in), .bit_valid(m_bit_valid),
    .start(m_start), .word_out(m_word_out), .word_valid(m_word_valid),
    .word_ready(m_word_ready), .busy(m_busy), .bit_count(m_bit_count),
    .overrun(m_overrun), .frame_err(m_frame_err), .clear_err(m_clear_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic s);
    bit_in    = b;
    start     = s;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] w, input logic rdy);
    word_ready = rdy;
    for (int i = 0; i < 16; i++) begin
      send_bit(w[i], i == 0);
    end
  endtask

  task automatic drain();
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] w;
    rst_n = 1'b0; ena = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; start = 1'b0;
    word_ready = 1'b0; clear_err = 1'b0;
    m_ena = 1'b1; m_bit_in = 1'b0; m_bit_valid = 1'b0; m_start = 1'b0;
    m_word_ready = 1'b0; m_clear_err = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_word_out", 32'(word_out), 32'h0);
    chk("rst_word_valid", 32'(word_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_bit_count", 32'(bit_count), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    tick();

    // 0x1234 LSB-first, unread
    w = 16'h1234;
    word_ready = 1'b0;
    for (int i = 0; i < 15; i++) send_bit(w[i], i == 0);
    chk("t1_count15", 32'(bit_count), 32'd15);
    chk("t1_busy_mid", 32'(busy), 32'h1);
    chk("t1_valid_early", 32'(word_valid), 32'h0);
    send_bit(w[15], 1'b0);
    chk("t1_valid", 32'(word_valid), 32'h1);
    chk("t1_word", 32'(word_out), 32'h1234);
    chk("t1_busy_done", 32'(busy), 32'h0);
    chk("t1_count_done", 32'(bit_count), 32'h0);
    tick(); tick(); tick();
    chk("t1_valid_hold", 32'(word_valid), 32'h1);
    drain();
    chk("t1_valid_fall", 32'(word_valid), 32'h0);
    chk("t1_word_kept", 32'(word_out), 32'h1234);

    // 0xBEEF MSB-first with gaps on the second instance
    w = 16'hBEEF;
    for (int i = 0; i < 16; i++) begin
      if (i % 3 == 1) begin
        m_bit_valid = 1'b0;
        m_bit_in    = ~w[15 - i];
        m_start     = 1'b1;
        tick(); tick();
        chk("t2_gap_count", 32'(m_bit_count), 32'(i));
        m_start = 1'b0;
      end
      m_bit_in    = w[15 - i];
      m_start     = (i == 0);
      m_bit_valid = 1'b1;
      tick();
      m_bit_valid = 1'b0;
      m_start     = 1'b0;
      if (i < 15) chk("t2_count", 32'(m_bit_count), 32'(i + 1));
    end
    chk("t2_valid", 32'(m_word_valid), 32'h1);
    chk("t2_word", 32'(m_word_out), 32'hBEEF);
    chk("t2_count_done", 32'(m_bit_count), 32'h0);

    // Back-to-back with word_ready held high
    send_frame(16'h00FF, 1'b1);
    chk("t3_valid_a", 32'(word_valid), 32'h1);
    chk("t3_word_a", 32'(word_out), 32'h00FF);
    send_frame(16'hA5A5, 1'b1);
    chk("t3_valid_b", 32'(word_valid), 32'h1);
    chk("t3_word_b", 32'(word_out), 32'hA5A5);
    chk("t3_overrun", 32'(overrun), 32'h0);
    tick();
    chk("t3_valid_fall", 32'(word_valid), 32'h0);
    word_ready = 1'b0;

    // Overrun: second frame dropped while the first is unread
    send_frame(16'h1111, 1'b0);
    send_frame(16'h2222, 1'b0);
    chk("t4_word_kept", 32'(word_out), 32'h1111);
    chk("t4_overrun", 32'(overrun), 32'h1);
    chk("t4_valid", 32'(word_valid), 32'h1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("t4_overrun_clr", 32'(overrun), 32'h0);
    drain();

    // Restart after 5 bits
    for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0);
    chk("t5_count5", 32'(bit_count), 32'd5);
    chk("t5_no_err_yet", 32'(frame_err), 32'h0);
    send_frame(16'h3C3C, 1'b0);
    chk("t5_frame_err", 32'(frame_err), 32'h1);
    chk("t5_word", 32'(word_out), 32'h3C3C);
    chk("t5_overrun", 32'(overrun), 32'h0);
    drain();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("t5_err_clr", 32'(frame_err), 32'h0);

    // Asynchronous reset mid-frame with a word pending
    send_frame(16'h5555, 1'b0);
    for (int i = 0; i < 9; i++) send_bit(1'b1, i == 0);
    chk("t6_count9", 32'(bit_count), 32'd9);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_word_out", 32'(word_out), 32'h0);
    chk("t6_valid", 32'(word_valid), 32'h0);
    chk("t6_busy", 32'(busy), 32'h0);
    chk("t6_count", 32'(bit_count), 32'h0);
    tick();
    rst_n = 1'b1;
    send_frame(16'h0F0F, 1'b0);
    chk("t6_word_after", 32'(word_out), 32'h0F0F);
    chk("t6_valid_after", 32'(word_valid), 32'h1);
    drain();

    // ena low freezes everything
    send_frame(16'h7777, 1'b0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    chk("t7_err_pre", 32'(frame_err), 32'h1);
    ena = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bit_valid  = 1'b1;
      start      = i[0];
      bit_in     = i[1];
      word_ready = ~i[0];
      clear_err  = 1'b1;
      tick();
    end
    bit_valid = 1'b0; start = 1'b0; word_ready = 1'b0; clear_err = 1'b0;
    chk("t7_count", 32'(bit_count), 32'd2);
    chk("t7_busy", 32'(busy), 32'h1);
    chk("t7_valid", 32'(word_valid), 32'h1);
    chk("t7_word", 32'(word_out), 32'h7777);
    chk("t7_frame_err", 32'(frame_err), 32'h1);
    ena = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
